// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_ctrl_pkg;

  // Instruction field widths
  localparam int unsigned OpW   = 4;
  localparam int unsigned RegW  = 4;
  localparam int unsigned InstW = 16;
  localparam int unsigned MathW = 7;

  // Opcodes
  localparam logic [OpW-1:0] OP_NOP = 4'd0;
  localparam logic [OpW-1:0] OP_XOR = 4'd1;
  localparam logic [OpW-1:0] OP_ADD = 4'd2;
  localparam logic [OpW-1:0] OP_SUB = 4'd3;
  localparam logic [OpW-1:0] OP_AND = 4'd4;
  localparam logic [OpW-1:0] OP_OR  = 4'd5;
  localparam logic [OpW-1:0] OP_DIV = 4'd6;
  localparam logic [OpW-1:0] OP_MOD = 4'd7;
  localparam logic [OpW-1:0] OP_LDI = 4'd8;

  // One-hot ALU enables; each bit gates one tri-state driver onto the ALU bus
  localparam logic [MathW-1:0] M_NONE = 7'b0000000;
  localparam logic [MathW-1:0] M_XOR  = 7'b1000000;
  localparam logic [MathW-1:0] M_ADD  = 7'b0100000;
  localparam logic [MathW-1:0] M_SUB  = 7'b0010000;
  localparam logic [MathW-1:0] M_AND  = 7'b0001000;
  localparam logic [MathW-1:0] M_OR   = 7'b0000100;
  localparam logic [MathW-1:0] M_DIV  = 7'b0000010;
  localparam logic [MathW-1:0] M_MOD  = 7'b0000001;

  // Controller states
  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWrite
  } state_e;

  // Instruction word layout; for LDI the {rs, rt} pair carries imm8
  typedef struct packed {
    logic [OpW-1:0]  op;
    logic [RegW-1:0] rd;
    logic [RegW-1:0] rs;
    logic [RegW-1:0] rt;
  } instr_t;

  // Zero-extended immediate taken from the low byte of an instruction
  function automatic logic [InstW-1:0] imm_of(instr_t i);
    return {8'h00, i.rs, i.rt};
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: one-hot ALU select plus instruction class flags.
module alu_op_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [OpW-1:0]   opcode_i,
  output logic [MathW-1:0] sel_o,
  output logic             is_alu_o,
  output logic             is_div_o,
  output logic             is_ldi_o,
  output logic             is_nop_o,
  output logic             is_illegal_o
);

  // Map opcode to select and class; anything unlisted is illegal and selects nothing
  always_comb begin
    sel_o        = M_NONE;
    is_alu_o     = 1'b0;
    is_div_o     = 1'b0;
    is_ldi_o     = 1'b0;
    is_nop_o     = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP: is_nop_o = 1'b1;
      OP_XOR: begin
        sel_o    = M_XOR;
        is_alu_o = 1'b1;
      end
      OP_ADD: begin
        sel_o    = M_ADD;
        is_alu_o = 1'b1;
      end
      OP_SUB: begin
        sel_o    = M_SUB;
        is_alu_o = 1'b1;
      end
      OP_AND: begin
        sel_o    = M_AND;
        is_alu_o = 1'b1;
      end
      OP_OR: begin
        sel_o    = M_OR;
        is_alu_o = 1'b1;
      end
      OP_DIV: begin
        sel_o    = M_DIV;
        is_div_o = 1'b1;
      end
      OP_MOD: begin
        sel_o    = M_MOD;
        is_div_o = 1'b1;
      end
      OP_LDI:  is_ldi_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Sequencing controller: accepts an instruction, decodes it, holds one ALU
// enable for the required cycles and issues the register-file write-back.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [InstW-1:0]  instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [RegW-1:0]   rf_raddr_a,
  output logic [RegW-1:0]   rf_raddr_b,
  input  logic [InstW-1:0]  rf_rdata_b,
  output logic [MathW-1:0]  math_out,
  output logic              rf_we,
  output logic [RegW-1:0]   rf_waddr,
  output logic              wb_imm_sel,
  output logic [InstW-1:0]  imm,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter start value for DIV/MOD; counts down to zero inclusive
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  instr_t     instr_q;
  logic       wb_imm_sel_q;
  logic       accept;
  logic       div_zero;

  logic [MathW-1:0] dec_sel;
  logic             dec_is_alu;
  logic             dec_is_div;
  logic             dec_is_ldi;
  logic             dec_is_nop;
  logic             dec_is_illegal;

  assign accept = instr_ready && instr_valid;

  // Decode the latched opcode so every class flag is stable for the whole instruction
  alu_op_decoder u_dec (
    .opcode_i     (instr_q.op),
    .sel_o        (dec_sel),
    .is_alu_o     (dec_is_alu),
    .is_div_o     (dec_is_div),
    .is_ldi_o     (dec_is_ldi),
    .is_nop_o     (dec_is_nop),
    .is_illegal_o (dec_is_illegal)
  );

  // State register and EXEC counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction latch; only loads on an accepted handshake so busy-time valids are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q      <= '0;
      wb_imm_sel_q <= 1'b0;
    end else if (accept) begin
      instr_q      <= instr_t'(instr);
      wb_imm_sel_q <= (instr[15:12] == OP_LDI);
    end
  end

  // Next-state, counter and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    math_out = M_NONE;
    rf_we    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    div_zero = (rf_rdata_b == '0);
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_is_nop) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (dec_is_illegal) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end else if (dec_is_ldi) begin
          state_d = StWrite;
        end else if (dec_is_div && div_zero) begin
          // Retire without ever enabling the divider or writing back
          done    = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d   = dec_is_div ? DivLoad : 4'd0;
          state_d = StExec;
        end
      end
      StExec: begin
        math_out = dec_sel;
        if (cnt_q == 4'd0) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: begin
        // Keep the ALU driving the bus through write-back; dec_sel is zero for LDI
        math_out = (dec_is_alu || dec_is_div) ? dec_sel : M_NONE;
        rf_we    = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Addresses and immediate come straight from the latch so they hold DECODE through WRITE
  assign rf_raddr_a  = instr_q.rs;
  assign rf_raddr_b  = instr_q.rt;
  assign rf_waddr    = instr_q.rd;
  assign imm         = imm_of(instr_q);
  assign wb_imm_sel  = wb_imm_sel_q;
  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/alu_ctrl_fsm.md
# alu_ctrl_fsm

Sequencing control unit that drives the 7-bit one-hot `math_out` select of the simple processor's ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes the opcode into register-file read addresses. It then asserts exactly one ALU enable for the required number of cycles and issues the register-file write-back. It sits between the instruction source and the ALU/register file.

## Interface
Parameters:
- `DIV_CYCLES`, default 4: number of EXEC cycles held for DIV/MOD; legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `instr` input 16: instruction word. Format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; LDI uses [7:0] as imm8.
- `instr_valid` input 1: `instr` is valid.
- `instr_ready` output 1: high only in IDLE.
- `rf_raddr_a` output 4: register-file read address feeding ALU `p`.
- `rf_raddr_b` output 4: register-file read address feeding ALU `q`.
- `rf_rdata_b` input 16: register-file asynchronous read data at `rf_raddr_b`, used for the divide-by-zero check.
- `math_out` output 7: one-hot ALU enable. Bit 6 XOR, 5 ADD, 4 SUB, 3 AND, 2 OR, 1 DIV, 0 MOD.
- `rf_we` output 1: register-file write enable.
- `rf_waddr` output 4: write address.
- `wb_imm_sel` output 1: 1 selects `imm` as write data, 0 selects the ALU bus.
- `imm` output 16: zero-extended imm8.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when an instruction retires.
- `err` output 1: one-cycle pulse, coincident with `done`, for an illegal opcode or divide by zero.

## Operation
- Opcodes:
  - 0 NOP
  - 1 XOR
  - 2 ADD
  - 3 SUB
  - 4 AND
  - 5 OR
  - 6 DIV
  - 7 MOD
  - 8 LDI
  - 9–15 illegal
- States: IDLE, DECODE, EXEC, WRITE.
- **IDLE:** `instr_ready`=1. On `instr_valid`, latch `instr` and go to DECODE.
- **DECODE:** drive `rf_raddr_a`=rs, `rf_raddr_b`=rt, `rf_waddr`=rd.
  - NOP: `done`, go to IDLE.
  - Illegal opcode: `done`+`err`, go to IDLE.
  - LDI: go to WRITE with `wb_imm_sel`=1, `imm`={8'h00, imm8}.
  - DIV/MOD with `rf_rdata_b`==0: `done`+`err`, go to IDLE, no write.
  - All other opcodes: go to EXEC and load the EXEC counter.
- **EXEC:** assert the decoded `math_out` bit. Hold for 1 cycle (XOR/ADD/SUB/AND/OR) or `DIV_CYCLES` cycles (DIV/MOD), then go to WRITE.
- **WRITE:**
  - `rf_we`=1 and `done`=1 for one cycle.
  - For ALU ops, `math_out` stays asserted so the bus is still driven.
  - For LDI, `math_out`=0.
  - Go to IDLE.
- `math_out` invariants:
  - At most one bit is ever high.
  - It is all-zero in IDLE, in DECODE, and for NOP/LDI/illegal opcodes, so no tri-state driver is enabled.
- Address, `imm`, and `wb_imm_sel` outputs are registered and hold stable from DECODE through WRITE.

## Timing
- Reset values:
  - State = IDLE.
  - `math_out`, `rf_we`, `done`, `err`, `busy`, `wb_imm_sel` = 0.
  - All address outputs and `imm` = 0.
  - `instr_ready` = 1.
- Reset asserted mid-instruction: outputs return to their reset values immediately (asynchronously). No write completes and no `done` is issued.
- Latency, with the accept at cycle N:

| Instruction | DECODE | EXEC | WRITE / retire | `instr_ready` high |
|---|---|---|---|---|
| ALU op | N+1 | N+2 | N+3 | N+4 |
| DIV/MOD | N+1 | N+2 … N+1+`DIV_CYCLES` | N+2+`DIV_CYCLES` | N+3+`DIV_CYCLES` |
| LDI | N+1 | — | N+2 | N+3 |
| NOP, illegal, divide by zero | N+1 (retire) | — | — | N+2 |

- Maximum issue rate: one instruction every 4 cycles (ALU op).
- `instr_valid` while `instr_ready`=0 is ignored, and the instruction is not latched.
- The EXEC counter is 4 bits, loaded with `DIV_CYCLES`-1 and decremented to 0; it never wraps.

## Structure
- Package `alu_ctrl_pkg` contains:
  - Opcode constants `OP_NOP`..`OP_LDI`.
  - The state enum.
  - One-hot `math_out` constants `M_XOR`=7'b1000000 … `M_MOD`=7'b0000001.
- Sub-module `alu_op_decoder` is combinational. It maps opcode to the one-hot select plus the class flags `is_alu`, `is_div`, `is_ldi`, `is_nop`, `is_illegal`.
- `alu_ctrl_fsm` holds the state register, the instruction latch, and the EXEC counter.

## Test plan
1. After reset, ADD r3,r1,r2 (`instr`=16'h2312) → `math_out`=7'b0100000 in cycles N+2 and N+3; `rf_we`=1 with `rf_waddr`=3 at N+3; `done` at N+3; `instr_ready` high at N+4.
2. DIV r4,r5,r6 with `DIV_CYCLES`=4 and `rf_rdata_b`=7 → `math_out`=7'b0000010 for cycles N+2..N+6; `rf_we` at N+6.
3. MOD with `rf_rdata_b`=0 → `done`+`err` at N+1; `math_out` stays 0; `rf_we` never asserts.
4. LDI r9,8'hA5 (16'h89A5) → at N+2 `rf_we`=1, `wb_imm_sel`=1, `imm`=16'h00A5, `math_out`=0. Opcode 16'hF000 → `err` at N+1.
5. Assert `rst` during EXEC of SUB → `math_out`=0, `rf_we`=0, `instr_ready`=1 immediately; no `done` pulse.
6. Back-to-back XOR/OR/AND stream with `instr_valid` held high → a one-hot check on `math_out` passes every cycle, and each instruction is accepted exactly once, 4 cycles apart.
